wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage that consumes the memory/writeback pipeline register outputs (O, D, IR, overflow) and drives the single register-file write port.
- Also accepts asynchronous multdiv completions.
- Buffers multdiv completions in a small FIFO.
- Arbitrates the one write port per cycle between the pipeline and the FIFO, and stalls upstream when the FIFO cannot drain.

Parameters:
- MD_DEPTH, 2, multdiv completion FIFO entries (1..4)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- mw_o  in  32  ALU result / PC+1 / T from pipeline register
- mw_d  in  32  load data from pipeline register
- mw_ir  in  32  instruction word from pipeline register
- mw_ovfl  in  1  ALU overflow flag from pipeline register
- mw_valid  in  1  pipeline register holds a real instruction (not a bubble)
- md_ready  in  1  multdiv offers a completed result this cycle
- md_result  in  32  multdiv result
- md_rd  in  5  multdiv destination register
- md_exc  in  1  multdiv exception (mul overflow / div by zero)
- md_is_div  in  1  1 = div, 0 = mul
- md_ack  out  1  completion accepted this cycle (combinational, = !full | draining)
- ctrl_writeEnable  out  1  register-file write enable
- ctrl_writeReg  out  5  register-file write address
- data_writeReg  out  32  register-file write data
- wb_stall  out  1  freeze pipeline registers upstream
- fwd_valid, fwd_reg[4:0], fwd_data[31:0]  out  only with WB_FWD_EN

Behaviour:
- Clock is clock; reset is synchronous and active-high. Both names and the polarity/synchronicity are fixed.
- Reset: FIFO empty, pointers 0, wb_stall=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, fwd_* = 0.
- Reset overrides any same-cycle md_ready: the completion is dropped and md_ack=0 in that cycle.
- Pipeline decode (opcode = mw_ir[31:27], rd = mw_ir[26:22], aluop = mw_ir[6:2]):
  - R-type (00000), aluop add: writes rd <= O; if mw_ovfl, writes r30 <= 1.
  - R-type sub: if mw_ovfl, writes r30 <= 3; otherwise rd <= O.
  - R-type mul/div (00110/00111): no pipeline write; the result returns via the md path.
  - Other R-type: rd <= O.
  - addi (00101): rd <= O; if mw_ovfl, r30 <= 2.
  - lw (01000): rd <= D.
  - jal (00011): r31 <= O.
  - setx (10101): r30 <= O.
  - sw, j, bne, blt, jr, bex and all others: no write.
- Writes are only produced when mw_valid=1. Any write to r0 is suppressed (ctrl_writeEnable=0).
- MD entry data: if md_exc, the entry becomes r30 <= 4 (mul) or 5 (div); otherwise md_rd <= md_result.
- Arbitration each cycle (combinational outputs, zero latency from inputs/FIFO head):
  - Pipeline write present: pipeline wins; FIFO holds.
  - Otherwise, FIFO non-empty: pop head and write it.
  - A pop in the same cycle as a push is legal. When count == MD_DEPTH, that pop frees the slot for the push.
- Starvation guard: when count == MD_DEPTH and a pipeline write is present, assert wb_stall.
  - The pipeline write still completes this cycle (the register's contents are presented again next cycle by the frozen latch and are written again — idempotent).
  - Next cycle, while wb_stall=1, the FIFO head has priority over the pipeline.
  - wb_stall registers: set on the condition above, cleared on the cycle after a pop.
- md_ack=1 iff count < MD_DEPTH, or a pop occurs this cycle. Multdiv must hold md_ready/data until it sees md_ack.
- Simultaneous push and pop on an empty FIFO: the entry is not bypassed; it is written at the earliest the next cycle.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: fwd_valid/fwd_reg/fwd_data register the write-port triple each cycle. This gives one-cycle-late data for the bypass unit covering regfile read-after-write. They reset to 0.
- Undefined: the ports are absent and no extra flops are built.

Decomposition:
- Package wb_pkg: opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_JAL, OP_SETX, OP_SW), ALU-op constants (ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV), register indices REG_RSTATUS=30 and REG_RA=31, rstatus codes 1..5.
- Sub-module wb_md_fifo: parameterised sync FIFO (push/pop/full/empty/count, 37-bit entries).

Test Plan:
- Reset, then lw with rd=5, D=0xDEADBEEF, mw_valid=1 -> same cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF.
- add with mw_ovfl=1, rd=7 -> write r30 <= 1. addi overflow -> r30 <= 2. sub overflow -> r30 <= 3. rd=0 with no overflow -> ctrl_writeEnable=0.
- md_ready with md_rd=9, md_result=42 while the pipeline writes for 3 cycles -> md_ack=1. r9 <= 42 is written on the first idle pipeline cycle.
- Two md completions (MD_DEPTH=2) plus continuous pipeline writes -> the third md_ready sees md_ack=0. wb_stall=1 the next cycle, the FIFO head is written, and wb_stall drops the cycle after the pop.
- md_exc=1, md_is_div=1 -> r30 <= 5. With md_is_div=0 -> r30 <= 4.
- Reset asserted with FIFO holding 1 entry and md_ready=1 -> next cycle FIFO empty, all outputs 0, and no write of either entry.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback definitions: opcode/ALU-op encodings, special registers, rstatus codes,
// write-port and multdiv-entry structs.
package wb_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] REG_RA      = 5'd31;

  localparam logic [31:0] RS_ADD_OVF  = 32'd1;
  localparam logic [31:0] RS_ADDI_OVF = 32'd2;
  localparam logic [31:0] RS_SUB_OVF  = 32'd3;
  localparam logic [31:0] RS_MUL_EXC  = 32'd4;
  localparam logic [31:0] RS_DIV_EXC  = 32'd5;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } md_entry_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_write_t;

  localparam int MD_ENTRY_W = $bits(md_entry_t);

  // A faulting multdiv op reports through rstatus instead of its destination.
  function automatic md_entry_t make_md_entry(input logic exc, input logic is_div,
                                              input logic [4:0] rd, input logic [31:0] result);
    md_entry_t e;
    if (exc) begin
      e.rd   = REG_RSTATUS;
      e.data = is_div ? RS_DIV_EXC : RS_MUL_EXC;
    end else begin
      e.rd   = rd;
      e.data = result;
    end
    return e;
  endfunction

endpackage

// File: rtl/wb_md_fifo.sv
// Generic synchronous FIFO, head visible combinationally; push and pop may share a cycle.
// Latency: one cycle push-to-head (no bypass); a push while full is accepted only with a pop.
module wb_md_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign pop_dat = r_mem[r_rd_ptr];
  assign w_pop   = pop && !empty;
  assign w_push  = push && (!full || w_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline vs buffered multdiv results onto one regfile port, zero-cycle write path.
// Backpressure: md_ack drops when the FIFO is full and not draining; wb_stall freezes upstream (WB_FWD_EN adds fwd_*).
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int MD_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mw_o,
  input  logic [31:0] mw_d,
  input  logic [31:0] mw_ir,
  input  logic        mw_ovfl,
  input  logic        mw_valid,
  input  logic        md_ready,
  input  logic [31:0] md_result,
  input  logic [4:0]  md_rd,
  input  logic        md_exc,
  input  logic        md_is_div,
  output logic        md_ack,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        wb_stall
`ifdef WB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data
`endif
);

  localparam int CW = $clog2(MD_DEPTH + 1);

  logic [4:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_aluop;
  wb_write_t   w_pipe;
  wb_write_t   w_out;
  md_entry_t   w_head;
  md_entry_t   w_push_entry;
  logic [MD_ENTRY_W-1:0] w_head_raw;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_count;
  logic        w_pop;
  logic        w_push;
  logic        w_pipe_wr;
  logic        r_stall;
  logic        w_unused;

  assign w_opcode = mw_ir[31:27];
  assign w_rd     = mw_ir[26:22];
  assign w_aluop  = mw_ir[6:2];
  assign w_unused = ^{mw_ir[21:7], mw_ir[1:0]};

  always_comb begin
    w_pipe = '0;
    if (mw_valid) begin
      case (w_opcode)
        OP_RTYPE: begin
          case (w_aluop)
            ALU_ADD: w_pipe = mw_ovfl ? {1'b1, REG_RSTATUS, RS_ADD_OVF} : {1'b1, w_rd, mw_o};
            ALU_SUB: w_pipe = mw_ovfl ? {1'b1, REG_RSTATUS, RS_SUB_OVF} : {1'b1, w_rd, mw_o};
            ALU_MUL, ALU_DIV: w_pipe = '0;
            default: w_pipe = {1'b1, w_rd, mw_o};
          endcase
        end
        OP_ADDI: w_pipe = mw_ovfl ? {1'b1, REG_RSTATUS, RS_ADDI_OVF} : {1'b1, w_rd, mw_o};
        OP_LW:   w_pipe = {1'b1, w_rd, mw_d};
        OP_JAL:  w_pipe = {1'b1, REG_RA, mw_o};
        OP_SETX: w_pipe = {1'b1, REG_RSTATUS, mw_o};
        OP_SW:   w_pipe = '0;
        default: w_pipe = '0;
      endcase
    end
    // An r0 target is not a write, so it must not block the FIFO from draining.
    if (w_pipe.rd == 5'd0) w_pipe.we = 1'b0;
  end

  // While stalled the FIFO head outranks the (frozen, already written) pipeline instruction.
  assign w_pop     = !reset && !w_empty && (r_stall || !w_pipe.we);
  assign w_pipe_wr = !reset && w_pipe.we && !(r_stall && !w_empty);
  assign md_ack    = !reset && (!w_full || w_pop);
  assign w_push    = md_ready && md_ack;
  assign w_push_entry = make_md_entry(md_exc, md_is_div, md_rd, md_result);
  assign w_head    = md_entry_t'(w_head_raw);

  wb_md_fifo #(
    .WIDTH (MD_ENTRY_W),
    .DEPTH (MD_DEPTH)
  ) u_md_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (w_push),
    .push_dat (w_push_entry),
    .pop      (w_pop),
    .pop_dat  (w_head_raw),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count)
  );

  always_comb begin
    w_out = '0;
    if (w_pop)          w_out = {1'b1, w_head.rd, w_head.data};
    else if (w_pipe_wr) w_out = w_pipe;
  end

  assign ctrl_writeEnable = w_out.we && (w_out.rd != 5'd0);
  assign ctrl_writeReg    = w_out.rd;
  assign data_writeReg    = w_out.data;
  assign wb_stall         = r_stall;

  always_ff @(posedge clock) begin
    if (reset)
      r_stall <= 1'b0;
    else if (w_pop)
      r_stall <= 1'b0;
    else if ((w_count == CW'(MD_DEPTH)) && w_pipe.we)
      r_stall <= 1'b1;
  end

`ifdef WB_FWD_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_valid <= 1'b0;
      fwd_reg   <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= ctrl_writeEnable;
      fwd_reg   <= ctrl_writeReg;
      fwd_data  <= data_writeReg;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected regfile writes are queued at stimulus time and
// popped by an independent write-port monitor; handshake/stall levels are checked inline.
module tb_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mw_o, mw_d, mw_ir;
  logic        mw_ovfl, mw_valid;
  logic        md_ready;
  logic [31:0] md_result;
  logic [4:0]  md_rd;
  logic        md_exc, md_is_div;
  logic        md_ack;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        wb_stall;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
`endif

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  wb_arbiter #(.MD_DEPTH(2)) dut (
    .clock            (clock),
    .reset            (reset),
    .mw_o             (mw_o),
    .mw_d             (mw_d),
    .mw_ir            (mw_ir),
    .mw_ovfl          (mw_ovfl),
    .mw_valid         (mw_valid),
    .md_ready         (md_ready),
    .md_result        (md_result),
    .md_rd            (md_rd),
    .md_exc           (md_exc),
    .md_is_div        (md_is_div),
    .md_ack           (md_ack),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .wb_stall         (wb_stall)
`ifdef WB_FWD_EN
    ,
    .fwd_valid        (fwd_valid),
    .fwd_reg          (fwd_reg),
    .fwd_data         (fwd_data)
`endif
  );

  always #5 clock = ~clock;

  // Monitor: every asserted write must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (ctrl_writeEnable) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got r%0d <= %h, required no write", ctrl_writeReg, data_writeReg);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ctrl_writeReg !== e.r || data_writeReg !== e.d) begin
          n_err++;
          $display("FAIL write_port: got r%0d <= %h, required r%0d <= %h", ctrl_writeReg, data_writeReg, e.r, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] alu);
    return {op, rd, 15'd0, alu, 2'b00};
  endfunction

  task automatic pipe(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] d,
                      input logic ov, input logic v);
    mw_ir = ir; mw_o = o; mw_d = d; mw_ovfl = ov; mw_valid = v;
  endtask

  task automatic md(input logic rdy, input logic [4:0] rd, input logic [31:0] res,
                    input logic exc, input logic is_div);
    md_ready = rdy; md_rd = rd; md_result = res; md_exc = exc; md_is_div = is_div;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back('{r: r, d: d});
  endtask

  task automatic to_neg();
    @(negedge clock);
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  localparam logic [4:0] R  = 5'b00000;
  localparam logic [4:0] LW = 5'b01000;

  initial begin
    reset = 1'b1;
    pipe(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    md(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    to_neg();
    chk("rst_we",    {31'd0, ctrl_writeEnable}, 32'd0);
    chk("rst_reg",   {27'd0, ctrl_writeReg},    32'd0);
    chk("rst_data",  data_writeReg,             32'd0);
    chk("rst_stall", {31'd0, wb_stall},         32'd0);
    chk("rst_ack",   {31'd0, md_ack},           32'd0);
    next();
    reset = 1'b0;

    // Pipeline decode, one instruction per cycle.
    pipe(mk_ir(LW, 5'd5, 5'd0), 32'h0, 32'hDEADBEEF, 1'b0, 1'b1); expect_wr(5'd5, 32'hDEADBEEF);
    to_neg();
    chk("lw_we", {31'd0, ctrl_writeEnable}, 32'd1);
    next();
    pipe(mk_ir(R, 5'd7, 5'd0), 32'h1234, 32'h0, 1'b1, 1'b1);       expect_wr(5'd30, 32'd1); next();
    pipe(mk_ir(5'b00101, 5'd6, 5'd0), 32'h99, 32'h0, 1'b1, 1'b1);  expect_wr(5'd30, 32'd2); next();
    pipe(mk_ir(R, 5'd8, 5'd1), 32'h77, 32'h0, 1'b1, 1'b1);         expect_wr(5'd30, 32'd3); next();
    pipe(mk_ir(R, 5'd0, 5'd0), 32'd123, 32'h0, 1'b0, 1'b1);
    to_neg();
    chk("r0_suppressed", {31'd0, ctrl_writeEnable}, 32'd0);
    next();
    pipe(mk_ir(R, 5'd4, 5'd1), 32'h55, 32'h0, 1'b0, 1'b1);         expect_wr(5'd4, 32'h55); next();
    pipe(mk_ir(5'b00011, 5'd0, 5'd0), 32'h100, 32'h0, 1'b0, 1'b1); expect_wr(5'd31, 32'h100); next();
    pipe(mk_ir(5'b10101, 5'd0, 5'd0), 32'd7, 32'h0, 1'b0, 1'b1);   expect_wr(5'd30, 32'd7); next();
    pipe(mk_ir(5'b00111, 5'd3, 5'd0), 32'h11, 32'h0, 1'b0, 1'b1);  next();
    pipe(mk_ir(R, 5'd3, 5'd6), 32'h22, 32'h0, 1'b0, 1'b1);
    to_neg();
    chk("mul_no_write", {31'd0, ctrl_writeEnable}, 32'd0);
    next();
    pipe(mk_ir(LW, 5'd9, 5'd0), 32'h0, 32'h33, 1'b0, 1'b0);
    to_neg();
    chk("bubble_no_write", {31'd0, ctrl_writeEnable}, 32'd0);
    next();

    // Multdiv result waits behind three pipeline writes.
    md(1'b1, 5'd9, 32'd42, 1'b0, 1'b0);
    pipe(mk_ir(LW, 5'd1, 5'd0), 32'h0, 32'd1, 1'b0, 1'b1); expect_wr(5'd1, 32'd1);
    to_neg();
    chk("md_ack_free", {31'd0, md_ack}, 32'd1);
    next();
    md(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    pipe(mk_ir(LW, 5'd2, 5'd0), 32'h0, 32'd2, 1'b0, 1'b1); expect_wr(5'd2, 32'd2); next();
    pipe(mk_ir(LW, 5'd3, 5'd0), 32'h0, 32'd3, 1'b0, 1'b1); expect_wr(5'd3, 32'd3); next();
    pipe(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);                 expect_wr(5'd9, 32'd42);
    to_neg();
    chk("md_drain_we", {31'd0, ctrl_writeEnable}, 32'd1);
    next();

    // Fill the FIFO under continuous pipeline writes, then watch the stall handshake.
    md(1'b1, 5'd11, 32'hA1, 1'b0, 1'b0);
    pipe(mk_ir(LW, 5'd20, 5'd0), 32'h0, 32'h120, 1'b0, 1'b1); expect_wr(5'd20, 32'h120); next();
    md(1'b1, 5'd12, 32'hB2, 1'b0, 1'b0);
    pipe(mk_ir(LW, 5'd21, 5'd0), 32'h0, 32'h121, 1'b0, 1'b1); expect_wr(5'd21, 32'h121); next();
    md(1'b1, 5'd13, 32'hC3, 1'b0, 1'b0);
    pipe(mk_ir(LW, 5'd22, 5'd0), 32'h0, 32'h122, 1'b0, 1'b1); expect_wr(5'd22, 32'h122);
    to_neg();
    chk("full_ack",      {31'd0, md_ack},   32'd0);
    chk("full_no_stall", {31'd0, wb_stall}, 32'd0);
    next();
    expect_wr(5'd11, 32'hA1);
    to_neg();
    chk("stall_set",      {31'd0, wb_stall}, 32'd1);
    chk("stall_pop_ack",  {31'd0, md_ack},   32'd1);
    next();
    md(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    expect_wr(5'd22, 32'h122);
    to_neg();
    chk("stall_cleared", {31'd0, wb_stall}, 32'd0);
    chk("refull_ack",    {31'd0, md_ack},   32'd0);
    next();
    pipe(32'h0, 32'h0, 32'h0, 1'b0, 1'b0); expect_wr(5'd12, 32'hB2);
    to_neg();
    chk("restall", {31'd0, wb_stall}, 32'd1);
    next();
    expect_wr(5'd13, 32'hC3);
    to_neg();
    chk("idle_pop_no_stall", {31'd0, wb_stall}, 32'd0);
    next();

    // Multdiv exceptions land in rstatus.
    md(1'b1, 5'd8, 32'hFFFF, 1'b1, 1'b1); next();
    md(1'b1, 5'd8, 32'hFFFF, 1'b1, 1'b0); expect_wr(5'd30, 32'd5); next();
    md(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);     expect_wr(5'd30, 32'd4); next();
    to_neg();
    next();

    // Reset with one entry buffered and a completion on offer.
    md(1'b1, 5'd20, 32'h77, 1'b0, 1'b0);
    pipe(mk_ir(LW, 5'd14, 5'd0), 32'h0, 32'h14, 1'b0, 1'b1); expect_wr(5'd14, 32'h14); next();
    reset = 1'b1;
    md(1'b1, 5'd21, 32'h88, 1'b0, 1'b0);
    pipe(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    to_neg();
    chk("rst_drops_ack", {31'd0, md_ack},           32'd0);
    chk("rst_no_write",  {31'd0, ctrl_writeEnable}, 32'd0);
    next();
    reset = 1'b0;
    md(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    to_neg();
    chk("post_rst_we",    {31'd0, ctrl_writeEnable}, 32'd0);
    chk("post_rst_reg",   {27'd0, ctrl_writeReg},    32'd0);
    chk("post_rst_data",  data_writeReg,             32'd0);
    chk("post_rst_stall", {31'd0, wb_stall},         32'd0);
    chk("post_rst_ack",   {31'd0, md_ack},           32'd1);
    next();
    next();
    next();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
